// File: rtl/parity_pkg.sv
// Shared types, defaults and reference parity function for the parity frame transmitter.
package parity_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ptx_state_t;

  // Reference parity of a default-width word; odd=1 selects odd parity.
  function automatic logic calc_parity(input logic [DEFAULT_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a WIDTH-bit word; shared with the downstream parity checker.
module parity_tree #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity_c
);

  assign parity_c = ^data;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial parity frame transmitter: WIDTH data bits LSB first, then one parity bit.
// Optional macro PARITY_ERR_INJECT_EN adds inject_err to corrupt one frame's parity.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          ODD        = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             parity_out,
`ifdef PARITY_ERR_INJECT_EN
  output logic             busy,
  input  logic             inject_err
`else
  output logic             busy
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  ptx_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             in_ready_d, ser_out_d, ser_valid_d, frame_start_d, parity_out_d, busy_d;
  logic             tree_par_c;
  logic             inj_c;
  logic             accept_c;
  logic             load_par_c;

  parity_tree #(.WIDTH(WIDTH)) u_tree (
    .data     (data_in),
    .parity_c (tree_par_c)
  );

`ifdef PARITY_ERR_INJECT_EN
  assign inj_c = inject_err;
`else
  assign inj_c = 1'b0;
`endif

  assign accept_c   = in_valid && in_ready;
  assign load_par_c = tree_par_c ^ ODD ^ inj_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      in_ready    <= 1'b0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      parity_out  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      in_ready    <= in_ready_d;
      ser_out     <= ser_out_d;
      ser_valid   <= ser_valid_d;
      frame_start <= frame_start_d;
      parity_out  <= parity_out_d;
      busy        <= busy_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    in_ready_d    = in_ready;
    ser_out_d     = ser_out;
    ser_valid_d   = ser_valid;
    frame_start_d = 1'b0;
    parity_out_d  = parity_out;
    busy_d        = busy;

    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      SHIFT: begin
        in_ready_d = 1'b0;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d    = PARITY;
          ser_out_d  = par_q;
          in_ready_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          ser_out_d = shreg_q[0];
          shreg_d   = shreg_q >> 1;
        end
      end
      PARITY: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Accept can only occur in IDLE or PARITY; bit 0 is presented right away.
    if (accept_c) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      shreg_d       = data_in >> 1;
      par_d         = load_par_c;
      parity_out_d  = load_par_c;
      in_ready_d    = 1'b0;
      ser_out_d     = data_in[0];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
    end
  end

endmodule
